param_updown_counter: RTL and testbench

//  Parametrised up/down counter, successor to the fixed 4-bit free-running up counter.

---
 rtl/param_updown_counter.sv | 100 ++++++++++
 tb/tb_param_updown_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse and sticky overflow.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module param_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MAX_VAL);

    if (WIDTH < 1 || PRESCALE < 1 ||
        longint'(MAX_VAL) >= (longint'(1) << WIDTH)) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH/MAX_VAL/PRESCALE");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] ps_q, ps_d;

    // A step fires on the PRESCALE-th enabled cycle; load restarts the window.
    assign step = en && (ps_q == PsLast);

    always_comb begin
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = step ? '0 : ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign step = en;
`endif

    assign boundary = step && !load && (up_dn ? (cnt_q == MaxQ) : (cnt_q == '0));

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = clr_ovf ? 1'b0 : ovf_q;
        if (load) begin
            cnt_d = (load_val > MaxQ) ? MaxQ : load_val;
        end else if (step) begin
            if (boundary) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (!sat_mode) begin
                    cnt_d = up_dn ? '0 : MaxQ;
                end
            end else begin
                cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, MAX_VAL=9): directed cases
// followed by randomized traffic against an arithmetic reference model.
module tb_param_updown_counter;

    localparam int MAXV = 9;
    localparam int PS   = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, sat_mode, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, ovf;

    int n_vec = 0;
    int n_err = 0;
    int m_q, m_tc, m_ovf, m_ps;

    param_updown_counter #(
        .WIDTH   (4),
        .MAX_VAL (MAXV),
        .PRESCALE(PS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up_dn   (up_dn),
        .sat_mode(sat_mode),
        .load    (load),
        .load_val(load_val),
        .clr_ovf (clr_ovf),
        .q       (q),
        .tc      (tc),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [3:0] lv, input logic c);
        rst_n = r; en = e; up_dn = u; sat_mode = s; load = l; load_val = lv; clr_ovf = c;
    endtask

    // Reference: count kept as a plain integer, boundary detected by leaving 0..MAXV.
    task automatic model_step();
        int  nxt;
        bit  stp;
        bit  bnd;
        stp = 0;
        bnd = 0;
        if (!rst_n) begin
            m_q = 0; m_tc = 0; m_ovf = 0; m_ps = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_q  = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                m_ps = 0;
            end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
                m_ps++;
                if (m_ps == PS) begin
                    m_ps = 0;
                    stp  = 1;
                end
`else
                stp = 1;
`endif
            end
            if (stp) begin
                nxt = m_q + (up_dn ? 1 : -1);
                if (nxt > MAXV || nxt < 0) begin
                    bnd = 1;
                    nxt = sat_mode ? m_q : (up_dn ? 0 : MAXV);
                end
                m_q = nxt;
            end
            if (bnd) begin
                m_tc  = 1;
                m_ovf = 1;
            end else if (clr_ovf) begin
                m_ovf = 0;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".q"}, int'(q), m_q);
        check({tag, ".tc"}, int'(tc), m_tc);
        check({tag, ".ovf"}, int'(ovf), m_ovf);
    endtask

    initial begin
        m_q = 0; m_tc = 0; m_ovf = 0; m_ps = 0;
        drive(0, 1, 1, 0, 1, 4'd15, 0);
        tick("rst0");
        tick("rst1");
        check("rst.q_const", int'(q), 0);
        check("rst.tc_const", int'(tc), 0);
        check("rst.ovf_const", int'(ovf), 0);

`ifndef COUNTER_PRESCALE_EN
        drive(1, 1, 1, 0, 0, 4'd0, 0);
        tick("release");
        check("release.q_const", int'(q), 1);

        drive(1, 0, 1, 0, 1, 4'd8, 0);
        tick("load8");
        drive(1, 1, 1, 0, 0, 4'd0, 0);
        tick("upwrap1");
        check("upwrap1.q_const", int'(q), 9);
        tick("upwrap2");
        check("upwrap2.q_const", int'(q), 0);
        check("upwrap2.tc_const", int'(tc), 1);
        tick("upwrap3");
        check("upwrap3.q_const", int'(q), 1);
        check("upwrap3.tc_const", int'(tc), 0);
        check("upwrap3.ovf_const", int'(ovf), 1);

        drive(1, 0, 0, 0, 1, 4'd0, 1);
        tick("load0");
        drive(1, 1, 0, 0, 0, 4'd0, 0);
        tick("dnwrap");
        check("dnwrap.q_const", int'(q), 9);
        check("dnwrap.tc_const", int'(tc), 1);
        drive(1, 0, 0, 1, 1, 4'd0, 0);
        tick("load0b");
        drive(1, 1, 0, 1, 0, 4'd0, 0);
        tick("dnsat1");
        check("dnsat1.q_const", int'(q), 0);
        check("dnsat1.tc_const", int'(tc), 1);
        tick("dnsat2");
        check("dnsat2.tc_const", int'(tc), 1);

        drive(1, 1, 1, 0, 1, 4'd15, 0);
        tick("clamp");
        check("clamp.q_const", int'(q), 9);
        check("clamp.tc_const", int'(tc), 0);
        drive(1, 1, 1, 1, 0, 4'd0, 1);
        tick("setclr");
        check("setclr.ovf_const", int'(ovf), 1);
        drive(1, 0, 1, 1, 0, 4'd0, 1);
        tick("clronly");
        check("clronly.ovf_const", int'(ovf), 0);

        drive(1, 1, 1, 0, 0, 4'd0, 0);
        tick("prewrap");
        drive(1, 0, 1, 0, 1, 4'd9, 0);
        tick("load9");
        drive(0, 1, 1, 0, 0, 4'd0, 0);
        tick("midrst");
        check("midrst.q_const", int'(q), 0);
        check("midrst.tc_const", int'(tc), 0);
        check("midrst.ovf_const", int'(ovf), 0);
`else
        drive(1, 1, 1, 0, 0, 4'd0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick("ps_run");
            check("ps_run.q_const", int'(q), k / PS);
        end
        drive(0, 0, 1, 0, 0, 4'd0, 0);
        tick("ps_rst");
        drive(1, 1, 1, 0, 0, 4'd0, 0);
        tick("ps_e1");
        drive(1, 1, 1, 0, 1, 4'd0, 0);
        tick("ps_load");
        drive(1, 1, 1, 0, 0, 4'd0, 0);
        for (int k = 3; k <= 6; k++) begin
            tick("ps_restart");
            check("ps_restart.q_const", int'(q), (k == 6) ? 1 : 0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                  4'($urandom), ($urandom_range(0, 9) == 0));
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
